// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle adder that reuses one 4-bit carry-lookahead slice across W = 4*NIBBLES bit operands, LSB nibble first.
// Optional macro SUBTRACT_EN adds a `sub` input that selects A-B (two's complement, cout=1 means no borrow).
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SUBTRACT_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Returns {carry_out, sum[3:0]} using two-level lookahead carries.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    state_t         state_r, next_state_s;
    logic           in_ready_r, out_valid_r, busy_r;
    logic           in_ready_s, out_valid_s, busy_s;
    logic [W-1:0]   a_r, b_r, sum_r, sum_upd_s, b_load_s;
    logic           carry_r, cout_r, c_load_s;
    logic [2:0]     idx_r;
    logic [4:0]     shift_s;
    logic [4:0]     nib_res_s;

`ifdef SUBTRACT_EN
    assign b_load_s = sub ? ~op_b : op_b;
    assign c_load_s = sub ? 1'b1 : cin;
`else
    assign b_load_s = op_b;
    assign c_load_s = cin;
`endif

    // Nibble slice select, shared CLA, and splice of the new nibble into the running sum.
    always_comb begin
        shift_s   = {idx_r, 2'b00};
        nib_res_s = cla4(4'(a_r >> shift_s), 4'(b_r >> shift_s), carry_r);
        sum_upd_s = (sum_r & ~(W'(4'hf) << shift_s)) | (W'(nib_res_s[3:0]) << shift_s);
    end

    // State and registered handshake/status outputs; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (ena) begin
            state_r     <= next_state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) next_state_s = RUN;
                else          next_state_s = IDLE;
            end
            RUN: begin
                if (idx_r == LAST_IDX) next_state_s = DONE;
                else                   next_state_s = RUN;
            end
            DONE: begin
                if (out_ready) next_state_s = IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output values for the upcoming state, so the flops above present them glitch-free.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (next_state_s)
            IDLE:    in_ready_s  = 1'b1;
            RUN:     busy_s      = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b1;
        endcase
    end

    // Operand capture and one nibble of addition per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx_r   <= 3'd0;
        end else if (ena) begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= op_a;
                        b_r     <= b_load_s;
                        carry_r <= c_load_s;
                        idx_r   <= 3'd0;
                    end
                end
                RUN: begin
                    sum_r   <= sum_upd_s;
                    carry_r <= nib_res_s[4];
                    if (idx_r == LAST_IDX) begin
                        cout_r <= nib_res_s[4];
                        idx_r  <= 3'd0;
                    end else begin
                        idx_r  <= idx_r + 3'd1;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule
